uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receiver paired with the UART transmitter: recovers 8N1 frames (start, 8 data LSB-first, stop)
//  from the asynchronous uart_rx pin and presents each byte on a valid/ready port.
//  Sits between the board RX pin and the core's MMIO UART register / RX FIFO.
//  Uses 16x oversampling with mid-bit sampling for clock-skew tolerance.
// PARAMETERS
//  CLK_FREQUENCY_HZ  100_000_000  system clock frequency
//  BAUD              9600         line rate; tick divisor DIV = CLK_FREQUENCY_HZ/(BAUD*16), integer, >=1
//  PARITY_ODD        0            parity sense when UART_RX_PARITY_EN defined (0 even, 1 odd)
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst_n      in   1  asynchronous active-low reset
//  uart_rx    in   1  serial line, idle high, asynchronous to clk
//  data       out  8  received byte, stable while valid
//  valid      out  1  byte available; held until ready
//  ready      in   1  consumer accepts byte when valid && ready
//  frame_err  out  1  one-cycle pulse: stop bit sampled low
//  overrun    out  1  one-cycle pulse: byte completed while valid && !ready; new byte dropped
//  busy       out  1  high whenever FSM not IDLE
//  parity_err out  1  (UART_RX_PARITY_EN only) parity mismatch of byte in data, valid with it
// BEHAVIOUR
//  Reset: data=0, valid=0, frame_err=0, overrun=0, busy=0, parity_err=0, FSM=IDLE, sync flops=1, counters=0.
//  Input: 2-flop synchronizer (reset to 1); all decisions use synced value rx_s.
//  Tick: counter 0..DIV-1, tick pulses when counter==DIV-1 then wraps; free-running out of reset.
//  os_cnt: 4-bit oversample counter, advances on tick, wraps 15->0.
//  FSM (transitions evaluated only on tick):
//   IDLE:  rx_s==0 -> START, os_cnt=0.
//   START: at os_cnt==7 (mid start) rx_s==0 -> DATA, os_cnt=0, bit_cnt=0; rx_s==1 -> IDLE (glitch reject).
//   DATA:  at os_cnt==15 sample rx_s into shift[bit_cnt] (LSB first); after bit 7 -> STOP (or PARITY).
//   PARITY (macro only): at os_cnt==15 sample parity bit -> STOP.
//   STOP:  at os_cnt==15 sample: 1 -> deliver byte, IDLE; 0 -> frame_err pulse, no delivery, BREAK.
//   BREAK: stay until rx_s==1, then IDLE (no false start on held-low line).
//  Delivery: data/valid update on the clk edge after the stop-sample tick (latency 1 clk).
//   valid falls on the clk after valid && ready.
//   Completion with valid && !ready: overrun pulse, data/valid unchanged.
//   Completion in same cycle as valid && ready: handshake completes, new byte loaded, valid stays 1, no overrun.
//  rst_n asserted mid-frame: immediate return to reset state; partial byte discarded.
//  Line sampled low again immediately after STOP -> next frame starts normally (back-to-back frames).
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8E1/8O1 per PARITY_ODD; PARITY state present;
//   parity_err registered with data, valid alongside valid; byte still delivered on mismatch.
//  Not defined: 8N1 only; PARITY state and parity_err port absent.
// STRUCTURE
//  Package uart_pkg: rx state enum (IDLE, START, DATA, PARITY, STOP, BREAK), OVERSAMPLE=16,
//   function baud_div(clk_hz, baud); shared with the transmitter.
//  Sub-module uart_baud_tick (counter + tick pulse, params CLK_FREQUENCY_HZ/BAUD/OVERSAMPLE).
// TESTING (CLK_FREQUENCY_HZ=1_600_000, BAUD=10_000 -> DIV=10, 160 clk/bit)
//  1 Send 0xA5 8N1, ready=1 -> valid pulse 1 clk, data=0xA5, frame_err=0, busy low after stop.
//  2 Low glitch of 40 clk on idle line -> return to IDLE, no valid, no frame_err.
//  3 Send 0x3C with stop bit low, line high again 320 clk later -> frame_err one pulse, no valid, BREAK until high.
//  4 ready=0, send 0x11 then 0x22 -> data=0x11 held, overrun pulse at 0x22 stop; ready=1 -> 0x11 accepted.
//  5 Back-to-back 0x00,0xFF,0x55 with ready=1 -> three valids, bytes in order, no errors.
//  6 rst_n low mid-DATA of 0x7E, release, send 0x81 -> only 0x81 delivered; macro on: even parity wrong -> parity_err=1 with data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding, oversample ratio and baud divisor helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_e;

   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clk pulse every CLK/(BAUD*OVERSAMPLE) clocks.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_FREQUENCY_HZ = 100_000_000,
   parameter int BAUD             = 9600,
   parameter int OVERSAMPLE       = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);

   localparam int DIV = CLK_FREQUENCY_HZ / (BAUD * OVERSAMPLE);
   // Keep a 1-bit counter when DIV==1 so the tick is simply always high.
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_tick;

   assign w_tick = (r_cnt == CW'(DIV - 1));
   assign o_tick = w_tick;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)    r_cnt <= '0;
      else if (w_tick) r_cnt <= '0;
      else             r_cnt <= r_cnt + CW'(1);
   end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver with valid/ready byte output.
// Define UART_RX_PARITY_EN for 8E1/8O1 frames (sense set by PARITY_ODD) and the o_parity_err port.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQUENCY_HZ = 100_000_000,
   parameter int BAUD             = 9600,
   parameter int PARITY_ODD       = 0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_uart_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic       o_parity_err
`endif
);

   logic [1:0] r_sync;
   logic       w_rx_s;
   logic       w_tick;
   rx_state_e  r_state;
   logic [3:0] r_os_cnt;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_done;

   uart_baud_tick #(
      .CLK_FREQUENCY_HZ (CLK_FREQUENCY_HZ),
      .BAUD             (BAUD),
      .OVERSAMPLE       (OVERSAMPLE)
   ) u_tick (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .o_tick  (w_tick)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= 2'b11;
      else          r_sync <= {r_sync[0], i_uart_rx};
   end
   assign w_rx_s = r_sync[1];
   assign o_busy = (r_state != IDLE);

`ifdef UART_RX_PARITY_EN
   localparam logic PAR_SENSE = (PARITY_ODD != 0);
   logic r_par_bit;
   logic w_par_err;
   assign w_par_err = (^{r_shift, r_par_bit}) ^ PAR_SENSE;
`else
   logic w_unused_parity;
   assign w_unused_parity = (PARITY_ODD != 0);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_os_cnt    <= 4'd0;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'd0;
         r_done      <= 1'b0;
         o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit   <= 1'b0;
`endif
      end else begin
         r_done      <= 1'b0;
         o_frame_err <= 1'b0;
         if (w_tick) begin
            r_os_cnt <= r_os_cnt + 4'd1;
            case (r_state)
               IDLE:
                  if (!w_rx_s) begin
                     r_state  <= START;
                     r_os_cnt <= 4'd0;
                  end
               // Re-check at mid start bit so short low glitches are rejected.
               START:
                  if (r_os_cnt == 4'd7) begin
                     if (w_rx_s) r_state <= IDLE;
                     else begin
                        r_state   <= DATA;
                        r_os_cnt  <= 4'd0;
                        r_bit_cnt <= 3'd0;
                     end
                  end
               DATA:
                  if (r_os_cnt == 4'd15) begin
                     r_shift[r_bit_cnt] <= w_rx_s;
                     r_bit_cnt          <= r_bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                     if (r_bit_cnt == 3'd7) r_state <= PARITY;
`else
                     if (r_bit_cnt == 3'd7) r_state <= STOP;
`endif
                  end
`ifdef UART_RX_PARITY_EN
               PARITY:
                  if (r_os_cnt == 4'd15) begin
                     r_par_bit <= w_rx_s;
                     r_state   <= STOP;
                  end
`endif
               STOP:
                  if (r_os_cnt == 4'd15) begin
                     if (w_rx_s) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                     end else begin
                        o_frame_err <= 1'b1;
                        r_state     <= BREAK;
                     end
                  end
               BREAK:
                  if (w_rx_s) r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // A completed byte may load in the same cycle the previous one is accepted.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data       <= 8'd0;
         o_valid      <= 1'b0;
         o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         o_parity_err <= 1'b0;
`endif
      end else begin
         o_overrun <= 1'b0;
         if (r_done) begin
            if (!o_valid || i_ready) begin
               o_data       <= r_shift;
               o_valid      <= 1'b1;
`ifdef UART_RX_PARITY_EN
               o_parity_err <= w_par_err;
`endif
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1.6 MHz / 10 kbaud (160 clk per bit).
// Honours UART_RX_PARITY_EN by inserting a parity bit and checking o_parity_err.
module tb_uart_rx;

   localparam int BIT = 160;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       ready;
   logic [7:0] data;
   logic       valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = 1'b0;
   logic perr;
   bit   par_flip = 1'b0;
   bit   perr_q[$];
`endif

   int checks = 0;
   int errors = 0;

   int vld_cycles, acc_cnt, fe_cnt, ov_cnt;
   logic [7:0] acc_q[$];

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQUENCY_HZ (1_600_000),
      .BAUD             (10_000),
      .PARITY_ODD       (0)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_uart_rx    (rx),
      .o_data       (data),
      .o_valid      (valid),
      .i_ready      (ready),
      .o_frame_err  (frame_err),
      .o_overrun    (overrun),
      .o_busy       (busy)
`ifdef UART_RX_PARITY_EN
      ,
      .o_parity_err (perr)
`endif
   );

   always @(negedge clk) begin
      if (valid) vld_cycles++;
      if (valid && ready) begin
         acc_cnt++;
         acc_q.push_back(data);
`ifdef UART_RX_PARITY_EN
         perr_q.push_back(perr);
`endif
      end
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic clear_mon();
      vld_cycles = 0; acc_cnt = 0; fe_cnt = 0; ov_cnt = 0;
      acc_q.delete();
`ifdef UART_RX_PARITY_EN
      perr_q.delete();
`endif
   endtask

   function automatic int last_acc();
      return (acc_q.size() > 0) ? int'(acc_q[acc_q.size()-1]) : -1;
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0; wait_clk(BIT);
      for (int k = 0; k < 8; k++) begin
         rx = b[k]; wait_clk(BIT);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ PAR_ODD ^ par_flip; wait_clk(BIT);
`endif
      rx = stop; wait_clk(BIT);
   endtask

   typedef struct {
      logic [7:0] b;
      logic       stop;
      int         extra_low;
      int         exp_vld;
      int         exp_fe;
   } vec_t;

   vec_t vecs[5];

   initial begin
      // Frames 0..3 go out back-to-back; the last has a low stop bit.
      vecs[0] = '{8'hA5, 1'b1, 0,   1, 0};
      vecs[1] = '{8'h00, 1'b1, 0,   1, 0};
      vecs[2] = '{8'hFF, 1'b1, 0,   1, 0};
      vecs[3] = '{8'h55, 1'b1, 0,   1, 0};
      vecs[4] = '{8'h3C, 1'b0, 160, 0, 1};

      rst_n = 1'b0; rx = 1'b1; ready = 1'b1;
      clear_mon();
      wait_clk(3);
      check("reset valid", valid, 0);
      check("reset data", data, 0);
      check("reset busy", busy, 0);
      check("reset frame_err", frame_err, 0);
      check("reset overrun", overrun, 0);
      rst_n = 1'b1;
      wait_clk(20);

      for (int i = 0; i < 5; i++) begin
         clear_mon();
         send_frame(vecs[i].b, vecs[i].stop);
         if (vecs[i].extra_low > 0) begin
            wait_clk(vecs[i].extra_low);
            check($sformatf("v%0d busy in break", i), busy, 1);
            rx = 1'b1;
            wait_clk(30);
         end
         check($sformatf("v%0d busy after", i), busy, 0);
         check($sformatf("v%0d valid cycles", i), vld_cycles, vecs[i].exp_vld);
         check($sformatf("v%0d accepted", i), acc_cnt, vecs[i].exp_vld);
         check($sformatf("v%0d frame_err", i), fe_cnt, vecs[i].exp_fe);
         if (vecs[i].exp_vld != 0) begin
            check($sformatf("v%0d data", i), last_acc(), int'(vecs[i].b));
`ifdef UART_RX_PARITY_EN
            check($sformatf("v%0d parity_err", i), int'(perr_q[0]), 0);
`endif
         end
      end

      // Short low glitch on an idle line.
      clear_mon();
      rx = 1'b0;
      wait_clk(30);
      check("glitch busy", busy, 1);
      wait_clk(10);
      rx = 1'b1;
      wait_clk(200);
      check("glitch busy after", busy, 0);
      check("glitch valid", vld_cycles, 0);
      check("glitch frame_err", fe_cnt, 0);

      // Overrun: consumer stalled across two frames.
      clear_mon();
      ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      check("ovr pulse", ov_cnt, 1);
      check("ovr valid held", valid, 1);
      check("ovr data held", data, 8'h11);
      check("ovr none accepted", acc_cnt, 0);
      ready = 1'b1;
      wait_clk(3);
      check("ovr accepted", acc_cnt, 1);
      check("ovr accepted data", last_acc(), 8'h11);
      check("ovr valid drop", valid, 0);

      // Reset in the middle of a 0x7E frame, then a clean 0x81.
      clear_mon();
      rx = 1'b0; wait_clk(BIT);
      rx = 1'b0; wait_clk(BIT);
      rx = 1'b1; wait_clk(BIT);
      rx = 1'b1; wait_clk(BIT);
      check("mid busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid rst busy", busy, 0);
      check("mid rst data", data, 0);
      rx = 1'b1;
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(BIT + 10);
`ifdef UART_RX_PARITY_EN
      par_flip = 1'b1;
`endif
      send_frame(8'h81, 1'b1);
      check("rst accepted", acc_cnt, 1);
      check("rst data", last_acc(), 8'h81);
      check("rst frame_err", fe_cnt, 0);
      check("rst busy after", busy, 0);
`ifdef UART_RX_PARITY_EN
      check("rst parity_err", (perr_q.size() > 0) ? int'(perr_q[0]) : -1, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
